// File: rtl/uart_multi_fifo_if.sv
// rtl/uart_multi_fifo_if.sv - handshake/status bundle for the multi-lane byte FIFO
interface uart_multi_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
);
    logic [31:0]                 size;
    logic                        write_strobe;
    logic [7:0]                  write_count;
    logic [LANES*DATA_WIDTH-1:0] write_data;
    logic [31:0]                 write_available;
    logic                        read_strobe;
    logic [DATA_WIDTH-1:0]       read_data;
    logic [31:0]                 read_count;
    logic                        overflow;
    logic                        underflow;
    logic                        full;
    logic                        empty;

    modport master (
        output write_strobe, write_count, write_data, read_strobe,
        input  size, write_available, read_data, read_count,
        input  overflow, underflow, full, empty
    );

    modport slave (
        input  write_strobe, write_count, write_data, read_strobe,
        output size, write_available, read_data, read_count,
        output overflow, underflow, full, empty
    );
endinterface

// File: rtl/uart_multi_fifo.sv
// rtl/uart_multi_fifo.sv - multi-lane write, single-pop byte FIFO with exact occupancy status
// Define UART_FIFO_OVERWRITE_EN to make excess writes discard the oldest entries instead of the new lanes.
module uart_multi_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LANES      = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_multi_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    generate
        if (LANES < 1 || LANES > DEPTH) begin : g_bad_lanes
            $error("uart_multi_fifo: LANES must be within 1..DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [CW-1:0]         count;
    logic                  overflow_q;
    logic                  underflow_q;

    logic [CW-1:0]         n_req;
    logic [CW-1:0]         free_eff;
    logic [CW-1:0]         accepted;
    logic [CW-1:0]         drop;
    logic [CW-1:0]         count_next;
    logic                  rd_ok;
    logic                  ovf_next;
    logic                  unf_next;

    always_comb begin
        n_req      = '0;
        rd_ok      = 1'b0;
        free_eff   = '0;
        accepted   = '0;
        drop       = '0;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        count_next = count;

        if (bus.write_strobe) begin
            n_req = (int'(bus.write_count) > LANES) ? CW'(LANES) : CW'(bus.write_count);
        end
        rd_ok    = bus.read_strobe && (count != '0);
        unf_next = bus.read_strobe && (count == '0);
        // A pop in the same cycle frees its slot for the incoming lanes.
        free_eff = CW'(DEPTH) - count + CW'(rd_ok);

`ifdef UART_FIFO_OVERWRITE_EN
        accepted = n_req;
        drop     = (n_req > free_eff) ? (n_req - free_eff) : '0;
`else
        accepted = (n_req < free_eff) ? n_req : free_eff;
        drop     = '0;
`endif
        ovf_next   = (accepted < n_req) || (drop != '0);
        count_next = count + accepted - CW'(rd_ok) - drop;
    end

    // Storage carries no reset; lanes beyond the accepted count are never written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < LANES; k++) begin
                if (CW'(k) < accepted) begin
                    mem[wr_ptr + ADDR_WIDTH'(k)] <= bus.write_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + ADDR_WIDTH'(accepted);
            rd_ptr      <= rd_ptr + ADDR_WIDTH'(CW'(rd_ok) + drop);
            count       <= count_next;
            overflow_q  <= ovf_next;
            underflow_q <= unf_next;
        end
    end

    assign bus.size            = 32'(DEPTH);
    assign bus.read_count      = 32'(count);
    assign bus.write_available = 32'(DEPTH) - 32'(count);
    assign bus.full            = (count == CW'(DEPTH));
    assign bus.empty           = (count == '0);
    assign bus.read_data       = mem[rd_ptr];
    assign bus.overflow        = overflow_q;
    assign bus.underflow       = underflow_q;
endmodule

// File: tb/tb_uart_multi_fifo.sv
// tb/tb_uart_multi_fifo.sv - scoreboard bench for uart_multi_fifo at DEPTH 8, LANES 4
module tb_uart_multi_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_multi_fifo_if #(.DATA_WIDTH(8), .LANES(4)) bus();
    uart_multi_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .LANES(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb [$];
    logic [7:0] pre_rd, exp_rd, last_rd;
    bit exp_rd_valid, exp_ovf, exp_unf;

    task automatic drive(input bit ws, input int wc, input logic [31:0] wd, input bit rs);
        int n, freec, dropped;
        bus.write_strobe = ws;
        bus.write_count  = 8'(wc);
        bus.write_data   = wd;
        bus.read_strobe  = rs;
        pre_rd       = bus.read_data;
        exp_unf      = rs && (sb.size() == 0);
        exp_rd_valid = rs && (sb.size() != 0);
        if (exp_rd_valid) exp_rd = sb.pop_front();
        n       = ws ? ((wc > 4) ? 4 : wc) : 0;
        freec   = 8 - sb.size();
        dropped = 0;
`ifdef UART_FIFO_OVERWRITE_EN
        for (int k = 0; k < n; k++) sb.push_back(wd[k*8 +: 8]);
        while (sb.size() > 8) begin
            void'(sb.pop_front());
            dropped++;
        end
        exp_ovf = (dropped > 0);
`else
        for (int k = 0; k < n; k++) if (k < freec) sb.push_back(wd[k*8 +: 8]);
        exp_ovf = (n > freec);
`endif
        @(posedge clk); #1;
        bus.write_strobe = 1'b0;
        bus.read_strobe  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic fill(input int cnt, input logic [7:0] base);
        int left, k;
        logic [31:0] wd;
        left = cnt;
        while (left > 0) begin
            k = (left > 4) ? 4 : left;
            for (int i = 0; i < 4; i++) wd[i*8 +: 8] = base + 8'(cnt - left + i);
            drive(1'b1, k, wd, 1'b0);
            left -= k;
        end
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 0, 32'h0, 1'b0);
        n_checks++; if (bus.read_count !== 32'd0) begin n_fail++; $display("FAIL reset_read_count got %0d want 0", bus.read_count); end
        n_checks++; if (bus.write_available !== 32'd8) begin n_fail++; $display("FAIL reset_write_available got %0d want 8", bus.write_available); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got %b%b want 00", bus.overflow, bus.underflow); end
        n_checks++; if (bus.size !== 32'd8) begin n_fail++; $display("FAIL reset_size got %0d want 8", bus.size); end
    endtask

    task automatic test_order();
        do_reset();
        drive(1'b1, 4, 32'h44332211, 1'b0);
        drive(1'b1, 3, 32'h00776655, 1'b0);
        n_checks++; if (bus.read_count !== 32'd7) begin n_fail++; $display("FAIL order_count got %0d want 7", bus.read_count); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 0, 32'h0, 1'b1);
            if (i < 7) begin
                n_checks++; if (pre_rd !== 8'(8'h11 * (i + 1))) begin n_fail++; $display("FAIL order_data[%0d] got %h want %h", i, pre_rd, 8'(8'h11 * (i + 1))); end
            end
            if (i == 6) begin
                n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL order_empty got %b want 1", bus.empty); end
            end
            n_checks++; if (bus.underflow !== exp_unf) begin n_fail++; $display("FAIL order_underflow[%0d] got %b want %b", i, bus.underflow, exp_unf); end
        end
        n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL order_underflow_pulse got %b want 1", bus.underflow); end
        drive(1'b0, 0, 32'h0, 1'b0);
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL order_underflow_clear got %b want 0", bus.underflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        fill(6, 8'h01);
        drive(1'b1, 4, 32'hA3A2A1A0, 1'b0);
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b want 1", bus.overflow); end
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", bus.full); end
        n_checks++; if (bus.read_count !== 32'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", bus.read_count); end
`ifdef UART_FIFO_OVERWRITE_EN
        n_checks++; if (bus.read_data !== 8'h03) begin n_fail++; $display("FAIL ovf_head got %h want 03", bus.read_data); end
`else
        n_checks++; if (bus.read_data !== 8'h01) begin n_fail++; $display("FAIL ovf_head got %h want 01", bus.read_data); end
`endif
        drive(1'b0, 0, 32'h0, 1'b0);
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", bus.overflow); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 0, 32'h0, 1'b1);
            last_rd = pre_rd;
            n_checks++; if (pre_rd !== exp_rd) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h want %h", i, pre_rd, exp_rd); end
        end
`ifdef UART_FIFO_OVERWRITE_EN
        n_checks++; if (last_rd !== 8'hA3) begin n_fail++; $display("FAIL ovf_last got %h want a3", last_rd); end
`else
        n_checks++; if (last_rd !== 8'hA1) begin n_fail++; $display("FAIL ovf_last got %h want a1", last_rd); end
`endif
    endtask

    task automatic test_simultaneous();
        do_reset();
        fill(8, 8'h30);
        drive(1'b1, 1, 32'h000000EE, 1'b1);
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL simul_overflow got %b want 0", bus.overflow); end
        n_checks++; if (bus.read_count !== 32'd8) begin n_fail++; $display("FAIL simul_count got %0d want 8", bus.read_count); end
        n_checks++; if (pre_rd !== 8'h30) begin n_fail++; $display("FAIL simul_head got %h want 30", pre_rd); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 0, 32'h0, 1'b1);
            last_rd = pre_rd;
            n_checks++; if (pre_rd !== exp_rd) begin n_fail++; $display("FAIL simul_drain[%0d] got %h want %h", i, pre_rd, exp_rd); end
        end
        n_checks++; if (last_rd !== 8'hEE) begin n_fail++; $display("FAIL simul_last got %h want ee", last_rd); end
    endtask

    task automatic test_wrap();
        do_reset();
        fill(6, 8'h40);
        for (int i = 0; i < 6; i++) drive(1'b0, 0, 32'h0, 1'b1);
        drive(1'b1, 4, 32'hD3D2D1D0, 1'b0);
        n_checks++; if (bus.read_count !== 32'd4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", bus.read_count); end
        n_checks++; if (dut.mem[6] !== 8'hD0 || dut.mem[0] !== 8'hD2) begin n_fail++; $display("FAIL wrap_index got %h/%h want d0/d2", dut.mem[6], dut.mem[0]); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 32'h0, 1'b1);
            n_checks++; if (pre_rd !== 8'(8'hD0 + i)) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, pre_rd, 8'(8'hD0 + i)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill(5, 8'h60);
        rst = 1'b1;
        bus.write_strobe = 1'b1; bus.write_count = 8'd4; bus.write_data = 32'hFFFFFFFF; bus.read_strobe = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.write_strobe = 1'b0; bus.read_strobe = 1'b0;
        sb.delete();
        n_checks++; if (bus.read_count !== 32'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL midrst_count got %0d/%b want 0/1", bus.read_count, bus.empty); end
        n_checks++; if (bus.write_available !== 32'd8) begin n_fail++; $display("FAIL midrst_avail got %0d want 8", bus.write_available); end
        n_checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses got %b%b want 00", bus.overflow, bus.underflow); end
        drive(1'b1, 1, 32'h0000005A, 1'b0);
        n_checks++; if (bus.read_data !== 8'h5A || bus.read_count !== 32'd1) begin n_fail++; $display("FAIL midrst_write got %h/%0d want 5a/1", bus.read_data, bus.read_count); end
        drive(1'b0, 0, 32'h0, 1'b1);
        n_checks++; if (pre_rd !== 8'h5A || bus.empty !== 1'b1) begin n_fail++; $display("FAIL midrst_read got %h/%b want 5a/1", pre_rd, bus.empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
            if (exp_rd_valid) begin
                n_checks++; if (pre_rd !== exp_rd) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, pre_rd, exp_rd); end
            end
            n_checks++; if (bus.read_count !== 32'(sb.size())) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want %0d", i, bus.read_count, sb.size()); end
            n_checks++; if (bus.overflow !== exp_ovf || bus.underflow !== exp_unf) begin n_fail++; $display("FAIL b2b_pulses[%0d] got %b%b want %b%b", i, bus.overflow, bus.underflow, exp_ovf, exp_unf); end
            n_checks++; if (bus.full !== (sb.size() == 8) || bus.empty !== (sb.size() == 0)) begin n_fail++; $display("FAIL b2b_flags[%0d] got %b%b want %b%b", i, bus.full, bus.empty, sb.size() == 8, sb.size() == 0); end
        end
    endtask

    initial begin
        bus.write_strobe = 1'b0;
        bus.write_count  = 8'd0;
        bus.write_data   = 32'h0;
        bus.read_strobe  = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_order();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_multi_fifo.md
# uart_multi_fifo

Parametrised multi-lane byte FIFO for the UART wishbone slave. It accepts 1..LANES data words per write strobe and returns one word per read strobe. It keeps exact occupancy, free-space, full/empty and overflow/underflow status, and handles simultaneous read and write correctly. It sits between the wishbone register interface (32-bit writes of up to 4 bytes) and the UART transmitter, and is also instantiated on the receive path.

## Interface
- DATA_WIDTH, 8, width of one FIFO entry
- ADDR_WIDTH, 4, depth is DEPTH = 2^ADDR_WIDTH entries; all DEPTH entries are usable
- LANES, 4, max entries per write strobe; legal range 1 <= LANES <= DEPTH, checked at elaboration
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- size  out  32  constant DEPTH
- write_strobe  in  1  write request this cycle
- write_count  in  8  number of lanes to write; 0 = no-op; values > LANES clamp to LANES
- write_data  in  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]; lane 0 is written first
- write_available  out  32  free entries, DEPTH - read_count
- read_strobe  in  1  pop one entry
- read_data  out  DATA_WIDTH  show-ahead head entry; undefined while empty
- read_count  out  32  occupied entries
- overflow  out  1  one-cycle pulse: write lanes dropped or old data overwritten
- underflow  out  1  one-cycle pulse: read_strobe while empty
- full  out  1  read_count == DEPTH
- empty  out  1  read_count == 0

## Operation
- State: storage array mem[DEPTH], rd_ptr/wr_ptr (ADDR_WIDTH bits, natural wrap modulo DEPTH), count (ADDR_WIDTH+1 bits).
- Storage is not reset; only pointers, count and status are.
- Per cycle:
  - n = write_strobe ? min(write_count, LANES) : 0
  - r = read_strobe && (count != 0)
  - free_eff = DEPTH - count + r; a read in the same cycle frees its slot for the write.
- Default mode (macro absent):
  - accepted a = min(n, free_eff); lanes 0..a-1 go to mem[wr_ptr+k]; lanes a..n-1 are dropped.
  - wr_ptr += a; rd_ptr += r; count += a - r.
  - overflow pulses iff a < n.
- Underflow: read_strobe with count == 0 pulses underflow and leaves rd_ptr unchanged. This holds even if a write lands the same cycle, because data written in a cycle is never readable in that cycle.
- Pointer arithmetic is done at ADDR_WIDTH bits, so a multi-lane write that crosses the top of the array wraps to index 0.
- Outputs read_count, write_available, full and empty are decoded from the registered count. read_data = mem[rd_ptr], combinational from registered state.

## Timing
- Reset values: read_count 0, write_available DEPTH, empty 1, full 0, overflow 0, underflow 0, size DEPTH; rd_ptr = wr_ptr = 0.
- rst asserted mid-operation discards all contents on the next edge; strobes in the reset cycle are ignored.
- Write latency: data is visible on read_data and counted in status 1 cycle after the strobe edge.
- Read: read_data is valid before the strobe; the next entry appears 1 cycle after the strobe edge.
- Write and read strobes may both be asserted every cycle; the FIFO sustains one pop and up to LANES pushes per clock.
- overflow and underflow are registered and high for exactly the cycle after the offending edge.

## Configuration
- UART_FIFO_OVERWRITE_EN defined:
  - all n lanes are always written; drop = max(0, n - free_eff) oldest entries are discarded.
  - rd_ptr += r + drop; count = min(count + n - r, DEPTH).
  - overflow pulses iff drop > 0.
  - Used on the receive path, where newest data wins.
- UART_FIFO_OVERWRITE_EN undefined: the reject-excess behaviour in Operation applies; stored data is never lost.

## Test plan
Parameters for all scenarios: ADDR_WIDTH=3 (DEPTH 8), LANES=4, DATA_WIDTH=8.
- Reset then idle -> read_count 0, write_available 8, empty 1, full 0, overflow/underflow 0.
- Write count 4 (lanes 0x11,0x22,0x33,0x44), then count 3 (0x55,0x66,0x77), then 8 reads -> bytes 0x11..0x77 in order; empty after the 7th read; the 8th read pulses underflow.
- Fill to 6 entries, then write count 4 (0xA0..0xA3):
  - default: lanes 0xA0,0xA1 kept, full 1, overflow pulse, read_count 8.
  - with macro: all 4 written, 2 oldest dropped, head is the 3rd original byte, overflow pulse.
- Fill to 8, then assert read_strobe with a 1-lane write of 0xEE in the same cycle -> no overflow, read_count stays 8, 0xEE is last out.
- Advance pointers to wr_ptr=6 and write 4 lanes -> entries land at indices 6,7,0,1 and read back in order across the wrap.
- Assert rst mid-burst with 5 entries stored -> the next cycle shows the reset values; a subsequent write/read round-trip of 0x5A is correct.
